dma_reg_responder: RTL and testbench
====================================

// Module: dma_reg_responder
// PURPOSE
//  Register-side responder for the DMA register bus (addr/wr_en/valid/wdata/rdata).
//  Decodes accesses into a 10-entry DMA register file and returns read data.
//  Runs a small transfer-count engine kicked off by CTRL.start, and raises irq on completion.
//  Sits between the register bus and the DMA datapath; it is the DUT end that the bench driver initiates into.
// PARAMETERS
//  BASE_ADDR  32'h0000_0400  byte address of the first register; registers are at BASE_ADDR+4*n.
//  RD_DEFAULT 32'h0000_0000  rdata returned for an unmapped read.
// PORTS
//  clk    in   1   single clock; everything is sampled on posedge.
//  reset  in   1   synchronous, active-low reset.
//  addr   in   32  byte address; only word-aligned addresses decode.
//  wr_en  in   1   1 = write, 0 = read; qualified by valid.
//  valid  in   1   access strobe; one access per cycle while high.
//  wdata  in   32  write data.
//  rdata  out  32  registered read data.
//  irq    out  1   level interrupt.
//  busy   out  1   engine is in BUSY.
// BEHAVIOUR
//  Reset (reset==0 at posedge): all registers 0 except CONFIG=32'h0000_0200 (intr_en=1); rdata=0; irq=0; busy=0; FSM=IDLE.
//  Write: valid&&wr_en at posedge updates the target register at that edge.
//  Read: valid&&!wr_en at posedge; rdata updates at that same edge (one-cycle latency) and holds until the next read.
//  Register map (offset, access):
//    0x00 INTR: [31:16] mask, RW; [15:0] status, W1C; bit0 = done.
//    0x04 CTRL: [0] start, W1S, self-clears; [15:1] w_count, RW; [16] io_mem, RW; [31:17] read as 0.
//    0x08 IO_ADDR, RW.  0x0C MEM_ADDR, RW.  0x10 EXTRA_INFO, RW.  0x1C DESCRIPTOR_ADDR, RW.
//    0x14 STATUS, RO: [0] busy; [1] done_sticky; [2] |ERROR_STATUS; [4:3] fsm state; rest 0.
//    0x18 TRANSFER_COUNT, RO: [15:0] words counted; rest 0.
//    0x20 ERROR_STATUS, W1C: [0] align_err; [1] zero_count; [2] ctrl_write_while_busy; [3] unmapped, only with the macro below.
//    0x24 CONFIG, RW: [7:0] priority; [8] auto_restart; [9] intr_en; rest read as 0.
//  A write to an RO register is dropped with no side effect.
//  Engine FSM states: IDLE=0, BUSY=1, DONE=2.
//    IDLE, on a start write:
//      w_count==0 -> set ERROR_STATUS[1] and stay in IDLE.
//      IO_ADDR[1:0]!=0 or MEM_ADDR[1:0]!=0 -> set ERROR_STATUS[0] and stay in IDLE.
//      otherwise clear TRANSFER_COUNT and done_sticky, then go to BUSY on the next edge.
//    BUSY: TRANSFER_COUNT increments by 1 per cycle; when TRANSFER_COUNT+1==w_count, go to DONE (w_count cycles in BUSY).
//    DONE: held for one cycle; set INTR.status[0] and done_sticky; then BUSY if CONFIG.auto_restart (count restarts at 0), else IDLE.
//  CTRL write while BUSY or DONE: the whole write is ignored, w_count is unchanged, and ERROR_STATUS[2] sets.
//  Same-cycle W1C and hardware set of the same bit: the set wins.
//  irq = CONFIG.intr_en && |(INTR.status & INTR.mask[15:0]); irq is combinational from registers.
//  Reset asserted mid-transfer: FSM returns to IDLE and all state is cleared at that edge; no DONE and no irq follow.
//  TRANSFER_COUNT is 16 bits and never wraps, because it is bounded by w_count <= 32767.
//  Read and write to the same register in one cycle is impossible (wr_en selects one).
//    A read of TRANSFER_COUNT or STATUS returns the pre-edge value.
// CONFIGURATION
//  DMA_REG_UNMAPPED_ERR_EN defined:
//    a valid access to an address outside the map, or not word-aligned, sets ERROR_STATUS[3];
//    such reads return 32'hDEAD_BEEF.
//  DMA_REG_UNMAPPED_ERR_EN undefined:
//    such reads return RD_DEFAULT and such writes are dropped;
//    ERROR_STATUS[3] reads 0 and is not writable.
// STRUCTURE
//  Shared package dma_reg_pkg holds:
//    register offset localparams (OFF_INTR..OFF_CONFIG);
//    typedef enum logic [1:0] {IDLE, BUSY, DONE} dma_state_e;
//    packed struct typedefs for CTRL and CONFIG;
//    reset-value constants.
//  One sub-module, dma_xfer_engine: the FSM and TRANSFER_COUNT.
//    Inputs: start pulse, w_count, auto_restart.
//    Outputs: state, count, done pulse.
//  The decode, register storage and read mux stay in the top module.
// TESTING
//  1 Reset, then read every offset -> all read 0 except CONFIG=32'h200; irq=0; busy=0.
//  2 Write IO_ADDR=32'h1000, MEM_ADDR=32'h2000, then CTRL=32'h0000_0009 (w_count=4, start) -> busy for 4 cycles;
//    TRANSFER_COUNT=4; INTR.status[0]=1; STATUS[1]=1; CTRL[0] reads 0.
//  3 INTR mask=32'h0001_0000, then run test 2 -> irq rises on the edge after DONE;
//    write INTR=32'h0001_0001 -> irq falls next cycle; mask is retained.
//  4 MEM_ADDR=32'h2002, start with w_count=2 -> FSM stays IDLE and ERROR_STATUS=32'h1;
//    write 32'h1 to ERROR_STATUS -> reads 0.
//  5 During BUSY, write CTRL=32'h0000_0021 -> ERROR_STATUS[2]=1 and w_count unchanged;
//    assert reset mid-BUSY -> busy=0 next edge and no irq.
//  6 Read addr BASE_ADDR+32'h40 -> with the macro: 32'hDEAD_BEEF and ERROR_STATUS[3]=1; without it: RD_DEFAULT.

Source files
------------

// File: rtl/dma_reg_pkg.sv
// Shared definitions for the DMA register responder: register offsets,
// engine state encoding, CTRL/CONFIG layouts and reset values.
package dma_reg_pkg;

    localparam logic [5:0] OFF_INTR            = 6'h00;
    localparam logic [5:0] OFF_CTRL            = 6'h04;
    localparam logic [5:0] OFF_IO_ADDR         = 6'h08;
    localparam logic [5:0] OFF_MEM_ADDR        = 6'h0C;
    localparam logic [5:0] OFF_EXTRA_INFO      = 6'h10;
    localparam logic [5:0] OFF_STATUS          = 6'h14;
    localparam logic [5:0] OFF_TRANSFER_COUNT  = 6'h18;
    localparam logic [5:0] OFF_DESCRIPTOR_ADDR = 6'h1C;
    localparam logic [5:0] OFF_ERROR_STATUS    = 6'h20;
    localparam logic [5:0] OFF_CONFIG          = 6'h24;

    // One past the last mapped byte offset.
    localparam logic [31:0] MAP_SPAN       = 32'h0000_0028;
    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dma_state_e;

    typedef struct packed {
        logic [14:0] rsvd;
        logic        io_mem;
        logic [14:0] w_count;
        logic        start;
    } dma_ctrl_t;

    typedef struct packed {
        logic [21:0] rsvd;
        logic        intr_en;
        logic        auto_restart;
        logic [7:0]  prio;
    } dma_cfg_t;

    localparam dma_cfg_t CONFIG_RST = '{rsvd: 22'd0, intr_en: 1'b1,
                                        auto_restart: 1'b0, prio: 8'h00};

endpackage

// File: rtl/dma_xfer_engine.sv
// Transfer-count engine: IDLE -> BUSY for w_count cycles -> DONE for one
// cycle, then back to IDLE or straight into another BUSY run.
module dma_xfer_engine
    import dma_reg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [14:0] w_count,
    input  logic        auto_restart,
    output dma_state_e  state,
    output logic [15:0] count,
    output logic        done
);

    // Done is visible for exactly the one cycle the FSM sits in DONE.
    assign done = (state == DONE);

    // State and word counter; count is cleared on every (re)entry to BUSY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            count <= 16'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= BUSY;
                    count <= 16'd0;
                end
                BUSY: begin
                    count <= count + 16'd1;
                    if (count + 16'd1 == {1'b0, w_count})
                        state <= DONE;
                end
                DONE: begin
                    if (auto_restart) begin
                        state <= BUSY;
                        count <= 16'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dma_reg_responder.sv
// DMA register-bus responder: address decode, register file, read mux and
// interrupt. Define DMA_REG_UNMAPPED_ERR_EN to flag unmapped/unaligned
// accesses in ERROR_STATUS[3] and return 32'hDEAD_BEEF for such reads.
module dma_reg_responder
    import dma_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter logic [31:0] RD_DEFAULT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic        valid,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        busy
);

    logic [15:0] intr_mask, intr_status;
    logic [14:0] w_count;
    logic        io_mem;
    logic [31:0] io_addr, mem_addr, extra_info, desc_addr;
    logic [3:0]  err_status;
    logic        done_sticky;
    dma_cfg_t    cfg;

    dma_state_e  state;
    logic [15:0] xfer_count;
    logic        done;

    logic [31:0] off, rd_val;
    logic        mapped, wr, ctrl_wr, start_req, zero_err, align_err, eng_start;
    logic        busy_err, unm_err;
    logic [3:0]  err_clr;
    logic [15:0] intr_clr;
    dma_ctrl_t   ctrl_wd;

    // Out-of-range addresses below BASE_ADDR wrap to huge offsets and fail the span check.
    assign off     = addr - BASE_ADDR;
    assign mapped  = (addr[1:0] == 2'b00) && (off < MAP_SPAN);
    assign wr      = valid && wr_en && mapped;
    assign ctrl_wr = wr && (off[5:0] == OFF_CTRL);
    assign ctrl_wd = dma_ctrl_t'(wdata);

    // Start qualification: zero count takes priority over misalignment.
    assign start_req = ctrl_wr && (state == IDLE) && ctrl_wd.start;
    assign zero_err  = start_req && (ctrl_wd.w_count == 15'd0);
    assign align_err = start_req && !zero_err &&
                       ((io_addr[1:0] != 2'b00) || (mem_addr[1:0] != 2'b00));
    assign eng_start = start_req && !zero_err && !align_err;
    assign busy_err  = ctrl_wr && (state != IDLE);

`ifdef DMA_REG_UNMAPPED_ERR_EN
    assign unm_err = valid && !mapped;
    assign err_clr = (wr && off[5:0] == OFF_ERROR_STATUS) ? wdata[3:0] : 4'd0;
`else
    assign unm_err = 1'b0;
    assign err_clr = (wr && off[5:0] == OFF_ERROR_STATUS) ? {1'b0, wdata[2:0]} : 4'd0;
`endif

    assign intr_clr = (wr && off[5:0] == OFF_INTR) ? wdata[15:0] : 16'd0;

    assign busy = (state == BUSY);
    assign irq  = cfg.intr_en && |(intr_status & intr_mask);

    dma_xfer_engine u_engine (
        .clk          (clk),
        .reset        (reset),
        .start        (eng_start),
        .w_count      (w_count),
        .auto_restart (cfg.auto_restart),
        .state        (state),
        .count        (xfer_count),
        .done         (done)
    );

    // Read mux over current (pre-edge) register contents.
    always_comb begin
        rd_val = RD_DEFAULT;
        if (mapped) begin
            case (off[5:0])
                OFF_INTR:            rd_val = {intr_mask, intr_status};
                OFF_CTRL:            rd_val = {15'd0, io_mem, w_count, 1'b0};
                OFF_IO_ADDR:         rd_val = io_addr;
                OFF_MEM_ADDR:        rd_val = mem_addr;
                OFF_EXTRA_INFO:      rd_val = extra_info;
                OFF_STATUS:          rd_val = {27'd0, state, |err_status, done_sticky, busy};
                OFF_TRANSFER_COUNT:  rd_val = {16'd0, xfer_count};
                OFF_DESCRIPTOR_ADDR: rd_val = desc_addr;
                OFF_ERROR_STATUS:    rd_val = {28'd0, err_status};
                OFF_CONFIG:          rd_val = cfg;
                default:             rd_val = RD_DEFAULT;
            endcase
        end else begin
`ifdef DMA_REG_UNMAPPED_ERR_EN
            rd_val = UNMAPPED_RDATA;
`else
            rd_val = RD_DEFAULT;
`endif
        end
    end

    // Register storage; W1C bits let a same-cycle hardware set win.
    always_ff @(posedge clk) begin
        if (!reset) begin
            intr_mask   <= 16'd0;
            intr_status <= 16'd0;
            w_count     <= 15'd0;
            io_mem      <= 1'b0;
            io_addr     <= 32'd0;
            mem_addr    <= 32'd0;
            extra_info  <= 32'd0;
            desc_addr   <= 32'd0;
            err_status  <= 4'd0;
            done_sticky <= 1'b0;
            cfg         <= CONFIG_RST;
            rdata       <= 32'd0;
        end else begin
            intr_status <= (intr_status & ~intr_clr) | {15'd0, done};
            err_status  <= (err_status & ~err_clr) |
                           {unm_err, busy_err, zero_err, align_err};
            if (eng_start)
                done_sticky <= 1'b0;
            else if (done)
                done_sticky <= 1'b1;
            if (wr) begin
                case (off[5:0])
                    OFF_INTR:            intr_mask <= wdata[31:16];
                    OFF_CTRL: if (state == IDLE) begin
                        w_count <= ctrl_wd.w_count;
                        io_mem  <= ctrl_wd.io_mem;
                    end
                    OFF_IO_ADDR:         io_addr    <= wdata;
                    OFF_MEM_ADDR:        mem_addr   <= wdata;
                    OFF_EXTRA_INFO:      extra_info <= wdata;
                    OFF_DESCRIPTOR_ADDR: desc_addr  <= wdata;
                    OFF_CONFIG:          cfg <= '{rsvd: 22'd0, intr_en: wdata[9],
                                                  auto_restart: wdata[8], prio: wdata[7:0]};
                    default: ;
                endcase
            end
            if (valid && !wr_en)
                rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_dma_reg_responder.sv
// Directed bench for dma_reg_responder; expected values are hand-derived.
module tb_dma_reg_responder;

    localparam logic [31:0] BASE = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        wr_en = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq, busy;

    int checks = 0;
    int errors = 0;

    dma_reg_responder #(.BASE_ADDR(BASE), .RD_DEFAULT(32'h0)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .valid(valid),
        .wdata(wdata), .rdata(rdata), .irq(irq), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr_en = 1'b1; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; wr_en = 1'b0; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        d = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        do_reset();
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++; if (irq !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_irq_busy got %b%b exp 00", irq, busy); end
        for (int i = 0; i < 10; i++) begin
            rd(BASE + 32'(4 * i), d);
            e = (i == 9) ? 32'h0000_0200 : 32'h0;
            checks++; if (d !== e) begin errors++; $display("FAIL reset_read off %0h got %h exp %h", 4 * i, d, e); end
        end
    endtask

    // Runs a 4-word transfer; optionally checks irq around DONE.
    task automatic run_xfer(input bit chk_irq);
        wr(BASE + 32'h08, 32'h1000);
        wr(BASE + 32'h0C, 32'h2000);
        wr(BASE + 32'h04, 32'h0000_0009);
        for (int i = 0; i < 4; i++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL xfer_busy cyc %0d got %b exp 1", i, busy); end
            @(posedge clk); #1;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL xfer_done_state busy got %b exp 0", busy); end
        if (chk_irq) begin
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_in_done got %b exp 0", irq); end
        end
        @(posedge clk); #1;
        if (chk_irq) begin
            checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_done got %b exp 1", irq); end
        end
    endtask

    task automatic test_transfer();
        logic [31:0] d;
        run_xfer(1'b0);
        rd(BASE + 32'h18, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL xfer_count got %h exp 4", d); end
        rd(BASE + 32'h00, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL xfer_intr got %h exp 1", d); end
        rd(BASE + 32'h14, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL xfer_status got %h exp 2", d); end
        rd(BASE + 32'h04, d);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL xfer_ctrl got %h exp 8", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL xfer_irq_unmasked got %b exp 0", irq); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        wr(BASE + 32'h00, 32'h0000_0001);
        wr(BASE + 32'h00, 32'h0001_0000);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq); end
        run_xfer(1'b1);
        wr(BASE + 32'h00, 32'h0001_0001);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b exp 0", irq); end
        rd(BASE + 32'h00, d);
        checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL irq_mask_kept got %h exp 00010000", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        wr(BASE + 32'h0C, 32'h2002);
        wr(BASE + 32'h04, 32'h0000_0005);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL align_busy got %b exp 0", busy); end
        rd(BASE + 32'h20, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL align_err got %h exp 1", d); end
        rd(BASE + 32'h14, d);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL align_status got %h exp 6", d); end
        wr(BASE + 32'h20, 32'h1);
        rd(BASE + 32'h20, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL align_w1c got %h exp 0", d); end
        wr(BASE + 32'h0C, 32'h2000);
        wr(BASE + 32'h04, 32'h0000_0001);
        rd(BASE + 32'h20, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL zero_count_err got %h exp 2", d); end
        wr(BASE + 32'h20, 32'h2);
    endtask

    task automatic test_busy_write_and_reset();
        logic [31:0] d;
        wr(BASE + 32'h04, 32'h0000_0011);
        wr(BASE + 32'h04, 32'h0000_0021);
        rd(BASE + 32'h20, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL busy_write_err got %h exp 4", d); end
        rd(BASE + 32'h04, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL busy_write_ctrl got %h exp 10", d); end
        rd(BASE + 32'h18, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL count_pre_edge got %h exp 3", d); end
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (irq !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_quiet got %b%b exp 00", irq, busy); end
        rd(BASE + 32'h00, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_intr got %h exp 0", d); end
    endtask

    task automatic test_auto_restart();
        logic [31:0] d;
        wr(BASE + 32'h24, 32'h0000_0300);
        wr(BASE + 32'h04, 32'h0000_0005);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_busy0 got %b exp 1", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_busy1 got %b exp 1", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_done got %b exp 0", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_restart got %b exp 1", busy); end
        rd(BASE + 32'h18, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ar_count got %h exp 0", d); end
        rd(BASE + 32'h00, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL ar_intr got %h exp 1", d); end
        do_reset();
    endtask

    task automatic test_unmapped();
        logic [31:0] d, e_rd, e_err;
`ifdef DMA_REG_UNMAPPED_ERR_EN
        e_rd = 32'hDEAD_BEEF; e_err = 32'h8;
`else
        e_rd = 32'h0; e_err = 32'h0;
`endif
        wr(BASE + 32'h40, 32'hFFFF_FFFF);
        rd(BASE + 32'h40, d);
        checks++; if (d !== e_rd) begin errors++; $display("FAIL unmapped_rd got %h exp %h", d, e_rd); end
        rd(BASE + 32'h20, d);
        checks++; if (d !== e_err) begin errors++; $display("FAIL unmapped_err got %h exp %h", d, e_err); end
        rd(BASE + 32'h26, d);
        checks++; if (d !== e_rd) begin errors++; $display("FAIL unaligned_rd got %h exp %h", d, e_rd); end
        wr(BASE + 32'h18, 32'hFFFF);
        rd(BASE + 32'h18, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ro_count got %h exp 0", d); end
        rd(BASE + 32'h24, d);
        wr(BASE + 32'h08, 32'h1234_5678);
        checks++; if (rdata !== 32'h200) begin errors++; $display("FAIL rdata_hold got %h exp 200", rdata); end
        rd(BASE + 32'h08, d);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL io_addr_rw got %h exp 12345678", d); end
    endtask

    initial begin
        test_reset();
        test_transfer();
        test_irq();
        test_errors();
        test_busy_write_and_reset();
        test_auto_restart();
        test_unmapped();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
